// File: rtl/ahb_mem_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and one memory slave.
// HREADYIN is the shared bus ready that the master side feeds back in.
interface ahb_mem_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic                  HREADYIN;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HREADYIN, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    input  HREADY, HRESP, HRDATA
  );
  modport slave (
    input  HSEL, HREADYIN, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA,
    output HREADY, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// AHB-Lite word-organised memory slave: byte-lane writes, NONSEQ wait states,
// zero-wait SEQ beats and a two-cycle ERROR response for illegal accesses.
module ahb_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter int                    WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic           HCLK,
  input  logic           HRESET,
  ahb_mem_slave_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;

  typedef struct packed {
    logic          wr;
    logic [2:0]    size;
    logic [LW-1:0] lane;
    logic [IW-1:0] idx;
  } req_t;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] off, widx, amask;
  logic                  legal, hready, hresp, wr_en;
  logic [DATA_WIDTH-1:0] rdata;
  logic [NB-1:0]         be;
  logic                  unused_burst;

  assign off   = bus.HADDR - BASE_ADDR;
  assign widx  = off >> LW;
  assign amask = (ADDR_WIDTH'(1) << bus.HSIZE) - ADDR_WIDTH'(1);
  assign legal = (bus.HADDR >= BASE_ADDR) && (widx < ADDR_WIDTH'(MEM_DEPTH)) &&
                 (bus.HSIZE <= 3'(LW)) && ((bus.HADDR & amask) == '0);
  assign unused_burst = ^bus.HBURST;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    hready  = 1'b1;
    hresp   = 1'b0;
    wr_en   = 1'b0;
    rdata   = '0;
    case (state_q)
      S_WAIT: begin
        hready = 1'b0;
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DATA: begin
        wr_en = req_q.wr;
        if (!req_q.wr) rdata = mem[req_q.idx];
      end
      S_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
    // Any cycle that completes (HREADY high) may accept the next address phase.
    if (hready) begin
      state_d = S_IDLE;
      if (bus.HSEL && bus.HREADYIN && bus.HTRANS[1]) begin
        req_d.wr   = bus.HWRITE;
        req_d.size = bus.HSIZE;
        req_d.lane = off[LW-1:0];
        req_d.idx  = widx[IW-1:0];
        if (!legal) state_d = S_ERR1;
        else if (!bus.HTRANS[0] && (WAIT_STATES > 0)) begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_STATES - 1);
        end else state_d = S_DATA;
      end
    end
  end

  // Lane b is enabled when it falls in the same size-aligned group as the start lane.
  always_comb begin
    be = '0;
    for (int b = 0; b < NB; b++)
      be[b] = (LW'(b) >> req_q.size) == (req_q.lane >> req_q.size);
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en)
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[req_q.idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
  end

  assign bus.HREADY = hready;
  assign bus.HRESP  = hresp;
  assign bus.HRDATA = rdata;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomised and directed AHB traffic checked cycle by cycle against a
// transaction-level model (per-beat response queue plus a byte-addressed memory).
module tb_ahb_mem_slave;
  localparam int          AW    = 32;
  localparam int          DW    = 32;
  localparam int          DEPTH = 60;
  localparam int          WS    = 3;
  localparam logic [31:0] BASE  = 32'h40;

  logic HCLK = 1'b0;
  logic HRESET = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  assign bus.HREADYIN = bus.HREADY;

  ahb_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .WAIT_STATES(WS), .BASE_ADDR(BASE)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus.slave)
  );

  typedef struct {
    bit rdy; bit resp; bit fin; bit wr;
    int idx; int lane; int sz;
  } beat_t;

  beat_t       q[$];
  logic [31:0] mm [DEPTH];
  int          checks = 0, errors = 0;
  int          waits = 0, errcyc = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_rd = '0;
  logic [31:0] pend_wd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Expected data-phase cycles for one accepted address phase.
  task automatic plan(input logic [31:0] a, input bit wr, input int sz, input bit seq);
    beat_t  e;
    longint off;
    bit     ok;
    off = longint'(a) - longint'(BASE);
    ok  = (off >= 0) && (off / 4 < DEPTH) && (sz <= 2) &&
          (longint'(a) % (longint'(1) << sz) == 0);
    e.resp = 1'b0; e.wr = wr; e.fin = 1'b0; e.sz = sz;
    e.idx  = ok ? int'(off / 4) : 0;
    e.lane = ok ? int'(off % 4) : 0;
    if (!ok) begin
      e.rdy = 1'b0; e.resp = 1'b1; q.push_back(e);
      e.rdy = 1'b1; q.push_back(e);
    end else begin
      e.rdy = 1'b0;
      if (!seq) repeat (WS) q.push_back(e);
      e.rdy = 1'b1; e.fin = 1'b1; q.push_back(e);
    end
  endtask

  always @(negedge HCLK) begin
    if (chk_en) begin
      beat_t       e;
      logic [31:0] erd;
      if (q.size() > 0) e = q.pop_front();
      else begin
        e.rdy = 1'b1; e.resp = 1'b0; e.fin = 1'b0; e.wr = 1'b0;
        e.idx = 0; e.lane = 0; e.sz = 0;
      end
      erd = (e.fin && !e.wr) ? mm[e.idx] : 32'h0;
      chk("hready", {31'b0, bus.HREADY}, {31'b0, e.rdy});
      chk("hresp",  {31'b0, bus.HRESP},  {31'b0, e.resp});
      chk("hrdata", bus.HRDATA, erd);
      if (bus.HREADY === 1'b0 && bus.HRESP === 1'b0) waits++;
      if (bus.HRESP === 1'b1) errcyc++;
      if (e.fin && !e.wr) last_rd = bus.HRDATA;
      if (e.fin && e.wr)
        for (int b = 0; b < 4; b++)
          if (b >= e.lane && b < e.lane + (1 << e.sz)) mm[e.idx][8*b +: 8] = bus.HWDATA[8*b +: 8];
      if (e.rdy && bus.HSEL && bus.HTRANS[1])
        plan(bus.HADDR, bus.HWRITE, int'(bus.HSIZE), bus.HTRANS[0]);
    end
  end

  // One address phase; HWDATA carries the previous beat's data phase.
  task automatic beat(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                      input bit wr, input logic [2:0] sz, input logic [31:0] wd);
    bit r;
    int n;
    n = 0;
    bus.HSEL = sel; bus.HTRANS = tr; bus.HADDR = a;
    bus.HWRITE = wr; bus.HSIZE = sz; bus.HWDATA = pend_wd;
    do begin
      @(negedge HCLK); r = bus.HREADY;
      @(posedge HCLK); #1;
      n++;
    end while (!r && n < 40);
    if (!r) begin
      checks++; errors++;
      $display("FAIL timeout waiting for HREADY addr=%h", a);
    end
    pend_wd = wd;
  endtask

  task automatic flush();
    beat(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
  endtask

  localparam logic [1:0] NSQ = 2'b10, SEQ = 2'b11;

  initial begin
    bus.HSEL = 0; bus.HTRANS = 0; bus.HADDR = 0; bus.HWRITE = 0;
    bus.HSIZE = 0; bus.HBURST = 0; bus.HWDATA = 0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hready", {31'b0, bus.HREADY}, 32'h1);
    chk("rst_hresp",  {31'b0, bus.HRESP},  32'h0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    HRESET = 1'b1;
    chk_en = 1'b1;

    // Fill every word with a known pattern.
    for (int i = 0; i < DEPTH; i++)
      beat(1'b1, (i == 0) ? NSQ : SEQ, BASE + 32'(4 * i), 1'b1, 3'd2, 32'hA500_0000 | 32'(i));
    flush();
    chk("model_init", mm[5], 32'hA500_0005);

    // NONSEQ word write then read, WS waits on each beat.
    waits = 0;
    beat(1, NSQ, BASE + 32'h10, 1, 3'd2, 32'hDEAD_BEEF);
    beat(1, NSQ, BASE + 32'h10, 0, 3'd2, 32'h0);
    flush();
    chk("t2_rdata", last_rd, 32'hDEAD_BEEF);
    chk("t2_waits", 32'(waits), 32'(2 * WS));

    // Byte write into lane 3; other lanes of HWDATA carry junk.
    beat(1, NSQ, BASE + 32'h10, 1, 3'd2, 32'h1122_3344);
    beat(1, NSQ, BASE + 32'h13, 1, 3'd0, 32'hAA5A_5A5A);
    beat(1, NSQ, BASE + 32'h10, 0, 3'd2, 32'h0);
    flush();
    chk("t3_byte", last_rd, 32'hAA22_3344);
    chk("t3_model", mm[4], 32'hAA22_3344);

    // INCR4 burst: waits on the first beat only.
    bus.HBURST = 3'b011;
    waits = 0;
    for (int i = 0; i < 4; i++)
      beat(1, (i == 0) ? NSQ : SEQ, BASE + 32'h20 + 32'(4 * i), 1, 3'd2, 32'h1000 + 32'(i));
    flush();
    chk("t4_wr_waits", 32'(waits), 32'(WS));
    for (int i = 0; i < 4; i++)
      beat(1, (i == 0) ? NSQ : SEQ, BASE + 32'h20 + 32'(4 * i), 0, 3'd2, 32'h0);
    flush();
    chk("t4_rd_last", last_rd, 32'h1003);
    chk("t4_waits", 32'(waits), 32'(2 * WS));
    bus.HBURST = 3'b000;

    // Reset asserted mid-WAIT of a write: outputs clear at once, write never lands.
    bus.HSEL = 1; bus.HTRANS = NSQ; bus.HADDR = BASE + 32'h20; bus.HWRITE = 1; bus.HSIZE = 3'd2;
    @(posedge HCLK); #1;
    bus.HSEL = 0; bus.HTRANS = 2'b00; bus.HWDATA = 32'hBADB_AD00;
    @(posedge HCLK); #1;
    chk("t1_in_wait", {31'b0, bus.HREADY}, 32'h0);
    chk_en = 1'b0;
    HRESET = 1'b0;
    #1;
    chk("t1_hready", {31'b0, bus.HREADY}, 32'h1);
    chk("t1_hresp",  {31'b0, bus.HRESP},  32'h0);
    chk("t1_hrdata", bus.HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    q.delete();
    chk_en = 1'b1;
    beat(1, NSQ, BASE + 32'h20, 0, 3'd2, 32'h0);
    flush();
    chk("t1_no_write", last_rd, 32'h1000);

    // Illegal accesses: out of range, misaligned, below base, oversize.
    errcyc = 0;
    beat(1, NSQ, BASE + 32'(4 * DEPTH), 0, 3'd2, 32'h0);
    flush();
    chk("t5_range_err", 32'(errcyc), 32'd2);
    beat(1, NSQ, BASE + 32'h1, 1, 3'd1, 32'hFFFF_FFFF);
    flush();
    chk("t5_align_err", 32'(errcyc), 32'd4);
    beat(1, NSQ, BASE - 32'h4, 0, 3'd2, 32'h0);
    beat(1, NSQ, BASE + 32'h8, 0, 3'd3, 32'h0);
    flush();
    chk("t5_more_err", 32'(errcyc), 32'd8);
    beat(1, NSQ, BASE, 0, 3'd2, 32'h0);
    flush();
    chk("t5_unchanged", last_rd, 32'hA500_0000);
    beat(1, NSQ, BASE + 32'(4 * (DEPTH - 1)), 0, 3'd2, 32'h0);
    flush();
    chk("t5_last_word", last_rd, 32'hA500_003B);

    // Back-to-back write then read of the same word.
    beat(1, NSQ, BASE, 1, 3'd2, 32'h5);
    beat(1, SEQ, BASE, 0, 3'd2, 32'h0);
    flush();
    chk("t6_fwd", last_rd, 32'h5);
    beat(1, SEQ, BASE + 32'h4, 1, 3'd2, 32'h7);
    beat(1, SEQ, BASE + 32'h4, 0, 3'd2, 32'h0);
    flush();
    chk("t6_fwd_seq", last_rd, 32'h7);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      int          k, lo;
      logic [31:0] a;
      logic [2:0]  sz;
      k  = int'($urandom_range(0, 9));
      sz = 3'($urandom_range(0, 2));
      lo = int'($urandom_range(0, 3)) & ~((1 << sz) - 1);
      a  = BASE + 32'(4 * int'($urandom_range(0, DEPTH - 1)) + lo);
      if (k == 0) a  = 32'($urandom_range(0, int'(BASE) + 4 * DEPTH + 16));
      if (k == 1) sz = 3'($urandom_range(0, 7));
      beat(k != 2, 2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)), sz, $urandom);
    end
    flush();
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
